// File: rtl/blockade_pkg.sv
// Shared types and constants for the Blockade-family ROM loader.
package blockade_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      HOLD  = 3'd3,
      RUN   = 3'd4
   } state_t;

   localparam logic [1:0] GAME_BLOCKADE = 2'd0;
   localparam logic [1:0] GAME_COMOTION = 2'd1;
   localparam logic [1:0] GAME_HUSTLE   = 2'd2;
   localparam logic [1:0] GAME_BLASTO   = 2'd3;

   localparam logic [7:0] IDX_ROM  = 8'd0;
   localparam logic [7:0] IDX_MODE = 8'd1;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// Loader (ioctl) side bus: the loader is master, the ROM load controller is slave.
interface rom_load_ctrl_if;

   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
      output ioctl_wait
   );

endinterface

// File: rtl/rom_load_ctrl.sv
// ROM download controller: stretches loader bytes into core writes and sequences core reset.
// Optional running byte checksum enabled by defining ROM_LOAD_CHECKSUM_EN.
module rom_load_ctrl
   import blockade_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int HOLD_CYCLES = 16,
   parameter int WR_CYCLES   = 2
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              user_reset,
   rom_load_ctrl_if.slave    ioctl,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic [1:0]        game_mode,
   output logic              core_reset,
   output logic              rom_loaded,
   output logic              addr_err,
   output logic [15:0]       checksum
);

   localparam logic [2:0] WR_LAST   = 3'(WR_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   logic [7:0] hold_cnt;
   logic [2:0] wr_cnt;
   logic       dl_done;
   logic       addr_ok;
   logic       enter_load;
   logic       accept;
   logic       mode_wr;

   assign addr_ok    = (ioctl.ioctl_addr >> ADDR_W) == '0;
   assign enter_load = (state == IDLE || state == RUN || state == HOLD) &&
                       ioctl.ioctl_download && (ioctl.ioctl_index == IDX_ROM);
   assign accept     = (state == LOAD) && ioctl.ioctl_download && ioctl.ioctl_wr &&
                       (ioctl.ioctl_index == IDX_ROM) && addr_ok;
   // Strobes during a stall are dropped, mode writes included.
   assign mode_wr    = ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_MODE) && (state != WRITE);

   assign ioctl.ioctl_wait = (state == WRITE);
   assign dn_wr            = (state == WRITE);
   assign core_reset       = (state != RUN) || user_reset;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         wr_cnt     <= '0;
         dl_done    <= 1'b0;
         dn_addr    <= '0;
         dn_data    <= '0;
         game_mode  <= GAME_BLOCKADE;
         rom_loaded <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         if (mode_wr)
            game_mode <= ioctl.ioctl_dout[1:0];
         case (state)
            IDLE, RUN, HOLD: begin
               if (enter_load) begin
                  state      <= LOAD;
                  rom_loaded <= 1'b0;
                  addr_err   <= 1'b0;
                  dl_done    <= 1'b0;
               end else if (mode_wr && state != HOLD) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end else if (state == HOLD) begin
                  if (hold_cnt == HOLD_LAST) begin
                     // A mode-only restart must not claim a ROM is present.
                     if (dl_done)
                        rom_loaded <= 1'b1;
                     state <= RUN;
                  end else begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end
            end
            LOAD: begin
               if (!ioctl.ioctl_download) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  dl_done  <= 1'b1;
               end else if (accept) begin
                  dn_addr <= ioctl.ioctl_addr[ADDR_W-1:0];
                  dn_data <= ioctl.ioctl_dout;
                  wr_cnt  <= '0;
                  state   <= WRITE;
               end else if (ioctl.ioctl_wr && ioctl.ioctl_index == IDX_ROM) begin
                  addr_err <= 1'b1;
               end
            end
            WRITE: begin
               if (wr_cnt == WR_LAST) begin
                  wr_cnt <= '0;
                  if (ioctl.ioctl_download) begin
                     state <= LOAD;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= '0;
                     dl_done  <= 1'b1;
                  end
               end else begin
                  wr_cnt <= wr_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ROM_LOAD_CHECKSUM_EN
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         checksum <= '0;
      else if (enter_load)
         checksum <= '0;
      else if (accept)
         checksum <= checksum + {8'h00, ioctl.ioctl_dout};
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: vector table for loader bytes, scoreboard for core writes.
module tb_rom_load_ctrl;
   import blockade_pkg::*;

   localparam int ADDR_W      = 14;
   localparam int HOLD_CYCLES = 16;
   localparam int WR_CYCLES   = 2;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
      bit          accept;
      bit          err_after;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } sb_t;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              user_reset = 1'b0;
   logic [ADDR_W-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic              dn_wr;
   logic [1:0]        game_mode;
   logic              core_reset;
   logic              rom_loaded;
   logic              addr_err;
   logic [15:0]       checksum;

   rom_load_ctrl_if bus ();

   rom_load_ctrl #(
      .ADDR_W     (ADDR_W),
      .HOLD_CYCLES(HOLD_CYCLES),
      .WR_CYCLES  (WR_CYCLES)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .user_reset(user_reset),
      .ioctl     (bus),
      .dn_addr   (dn_addr),
      .dn_data   (dn_data),
      .dn_wr     (dn_wr),
      .game_mode (game_mode),
      .core_reset(core_reset),
      .rom_loaded(rom_loaded),
      .addr_err  (addr_err),
      .checksum  (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   int          n_pass = 0;
   int          n_total = 0;
   int          n_pulses = 0;
   sb_t         sb[$];
   vec_t        vecs[8];
   logic [15:0] csum_model = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] exp_checksum();
`ifdef ROM_LOAD_CHECKSUM_EN
      return csum_model;
`else
      return 16'h0000;
`endif
   endfunction

   // Write monitor: pops the scoreboard on each dn_wr rise and checks pulse width.
   int len = 0;
   bit in_pulse = 1'b0;
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         len = 0;
         in_pulse = 1'b0;
      end else if (dn_wr) begin
         if (!in_pulse) begin
            n_pulses++;
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL dn_wr_unexpected: got write addr 0x%0h data 0x%0h, expected none", dn_addr, dn_data);
            end else begin
               sb_t e;
               e = sb.pop_front();
               check("dn_addr", dn_addr, e.addr);
               check("dn_data", dn_data, e.data);
            end
         end
         in_pulse = 1'b1;
         len++;
      end else if (in_pulse) begin
         check("dn_wr_width", len, WR_CYCLES);
         check("wait_tracks_wr", bus.ioctl_wait, 0);
         in_pulse = 1'b0;
         len = 0;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.ioctl_wait; i++) tick();
      check("wait_release", bus.ioctl_wait, 0);
   endtask

   task automatic start_download();
      bus.ioctl_index    = IDX_ROM;
      bus.ioctl_download = 1'b1;
      tick();
      csum_model = '0;
      n_pulses   = 0;
   endtask

   task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input bit acc);
      sb_t e;
      bus.ioctl_index = IDX_ROM;
      bus.ioctl_addr  = a;
      bus.ioctl_dout  = d;
      bus.ioctl_wr    = 1'b1;
      if (acc) begin
         e.addr = a[ADDR_W-1:0];
         e.data = d;
         sb.push_back(e);
         csum_model = csum_model + {8'h00, d};
      end
      tick();
      bus.ioctl_wr = 1'b0;
      check(acc ? "stall_on_accept" : "no_stall_on_reject", bus.ioctl_wait, acc);
      wait_idle();
   endtask

   task automatic count_to_loaded(output int n, output bit cr_ok);
      n = 0;
      cr_ok = 1'b1;
      while (!rom_loaded && n < 60) begin
         tick();
         n++;
         if (!rom_loaded && !core_reset) cr_ok = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1);
   end

   initial begin
      int n;
      bit cr_ok;
      sb_t e;

      vecs[0] = '{25'h0000000, 8'h01, 1'b1, 1'b0};
      vecs[1] = '{25'h0000001, 8'h02, 1'b1, 1'b0};
      vecs[2] = '{25'h0000002, 8'h03, 1'b1, 1'b0};
      vecs[3] = '{25'h0000003, 8'h04, 1'b1, 1'b0};
      vecs[4] = '{25'h0004000, 8'h55, 1'b0, 1'b1};
      vecs[5] = '{25'h0003FFF, 8'hFF, 1'b1, 1'b1};
      vecs[6] = '{25'h1FFFFFF, 8'hAA, 1'b0, 1'b1};
      vecs[7] = '{25'h0000010, 8'h80, 1'b1, 1'b1};

      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      bus.ioctl_index    = IDX_ROM;

      repeat (3) tick();
      check("rst_core_reset", core_reset, 1);
      check("rst_wait", bus.ioctl_wait, 0);
      check("rst_dn_wr", dn_wr, 0);
      check("rst_dn_addr", dn_addr, 0);
      check("rst_dn_data", dn_data, 0);
      check("rst_flags", {rom_loaded, addr_err}, 0);
      check("rst_checksum", checksum, 0);
      check("rst_game_mode", game_mode, GAME_BLOCKADE);
      reset_n = 1'b1;
      tick();
      check("idle_core_reset", core_reset, 1);

      // Download 1: four clean bytes.
      start_download();
      for (int i = 0; i < 4; i++) begin
         rom_byte(vecs[i].addr, vecs[i].data, vecs[i].accept);
         check("addr_err_seq", addr_err, vecs[i].err_after);
      end
      bus.ioctl_download = 1'b0;
      count_to_loaded(n, cr_ok);
      check("dl1_loaded_latency", n, HOLD_CYCLES + 1);
      check("dl1_core_reset_hold", cr_ok, 1);
      check("dl1_run_core_reset", core_reset, 0);
      check("dl1_pulses", n_pulses, 4);
      check("dl1_checksum", checksum, exp_checksum());
      user_reset = 1'b1;
      #1 check("user_reset_on", core_reset, 1);
      user_reset = 1'b0;
      #1 check("user_reset_off", core_reset, 0);

      // Download 2: out-of-range bytes, top address, then download falls mid-write.
      start_download();
      check("dl2_core_reset", core_reset, 1);
      check("dl2_rom_loaded_clr", rom_loaded, 0);
      for (int i = 4; i < 8; i++) begin
         rom_byte(vecs[i].addr, vecs[i].data, vecs[i].accept);
         check("addr_err_seq", addr_err, vecs[i].err_after);
      end
      e.addr = 14'h0020;
      e.data = 8'h11;
      sb.push_back(e);
      csum_model = csum_model + 16'h0011;
      bus.ioctl_addr = 25'h20;
      bus.ioctl_dout = 8'h11;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr = 1'b0;
      check("fall_first_write_cycle", dn_wr, 1);
      bus.ioctl_download = 1'b0;
      count_to_loaded(n, cr_ok);
      check("fall_mid_write_latency", n, WR_CYCLES + HOLD_CYCLES);
      check("dl2_pulses", n_pulses, 3);
      check("dl2_checksum", checksum, exp_checksum());

      // Mode byte while running restarts the core.
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = IDX_MODE;
      bus.ioctl_dout     = 8'h03;
      bus.ioctl_wr       = 1'b1;
      tick();
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_download = 1'b0;
      check("mode_latched", game_mode, GAME_BLASTO);
      n = 0;
      while (core_reset && n < 60) begin
         n++;
         tick();
      end
      check("mode_hold_len", n, HOLD_CYCLES);
      check("mode_run_core_reset", core_reset, 0);

      // Download 3: strobe during a stall is ignored; then reset mid-write.
      start_download();
      check("dl3_addr_err_clr", addr_err, 0);
      check("dl3_rom_loaded_clr", rom_loaded, 0);
      e.addr = 14'h0005;
      e.data = 8'h3C;
      sb.push_back(e);
      csum_model = csum_model + 16'h003C;
      bus.ioctl_index = IDX_ROM;
      bus.ioctl_addr  = 25'h5;
      bus.ioctl_dout  = 8'h3C;
      bus.ioctl_wr    = 1'b1;
      tick();
      bus.ioctl_addr = 25'h6;
      bus.ioctl_dout = 8'h99;
      tick();
      bus.ioctl_wr = 1'b0;
      wait_idle();
      check("stall_wr_ignored_addr", dn_addr, 14'h0005);
      check("stall_wr_ignored_data", dn_data, 8'h3C);
      check("dl3_checksum", checksum, exp_checksum());

      e.addr = 14'h0007;
      e.data = 8'h42;
      sb.push_back(e);
      bus.ioctl_addr = 25'h7;
      bus.ioctl_dout = 8'h42;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr = 1'b0;
      #6 reset_n = 1'b0;
      #1;
      check("midwrite_rst_dn_wr", dn_wr, 0);
      check("midwrite_rst_wait", bus.ioctl_wait, 0);
      check("midwrite_rst_core_reset", core_reset, 1);
      check("midwrite_rst_rom_loaded", rom_loaded, 0);
      check("midwrite_rst_game_mode", game_mode, GAME_BLOCKADE);
      bus.ioctl_download = 1'b0;
      @(negedge clk_sys);
      #2 reset_n = 1'b1;
      tick();
      check("post_rst_core_reset", core_reset, 1);
      check("post_rst_dn_addr", dn_addr, 0);

      // Mode byte from IDLE also passes through the hold and then runs.
      bus.ioctl_index = IDX_MODE;
      bus.ioctl_dout  = 8'h02;
      bus.ioctl_wr    = 1'b1;
      tick();
      bus.ioctl_wr = 1'b0;
      check("idle_mode_latched", game_mode, GAME_HUSTLE);
      check("idle_mode_hold", core_reset, 1);
      repeat (HOLD_CYCLES + 2) tick();
      check("idle_mode_run", core_reset, 0);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
